// File: rtl/snake_pkg.sv
// snake_pkg: shared state/direction types and default timing constants
// for the snake game controller, plus direction helper functions.
package snake_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    OVER  = 3'd3,
    WIN   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  localparam int DEF_TICK_DIV   = 50;
  localparam int DEF_MIN_DIV    = 10;
  localparam int DEF_SPEED_STEP = 5;
  localparam int DEF_MAX_SCORE  = 140;
  localparam int DEF_BLINK_DIV  = 25;

  // Encoding pairs opposites on bit 0: UP/DOWN, LEFT/RIGHT.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

  // Pulse vector is {up,down,left,right}; highest bit wins.
  function automatic dir_t pick_dir(input logic [3:0] p);
    dir_t d;
    if (p[3])      d = UP;
    else if (p[2]) d = DOWN;
    else if (p[1]) d = LEFT;
    else           d = RIGHT;
    return d;
  endfunction

endpackage

// File: rtl/snake_game_ctrl_move_timer.sv
// move_timer: programmable move-period counter with freeze and speed-up.
// Ports: clk, rst, clear (reload defaults), run (count), speed_up, move_tick.
module move_timer #(
  parameter int TICK_DIV   = snake_pkg::DEF_TICK_DIV,
  parameter int MIN_DIV    = snake_pkg::DEF_MIN_DIV,
  parameter int SPEED_STEP = snake_pkg::DEF_SPEED_STEP
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  input  logic speed_up,
  output logic move_tick
);

  localparam int PW = $clog2(TICK_DIV + 1);

  // period: target for the next reload; active: period of the
  // count in progress, so a speed-up never truncates it.
  logic [PW-1:0] period;
  logic [PW-1:0] active;
  logic [PW-1:0] count;
  logic [PW-1:0] stepped;
  logic [PW-1:0] period_nxt;

  // Saturating step, compared before subtracting to avoid underflow.
  always_comb begin
    stepped = PW'(MIN_DIV);
    if (int'(period) > MIN_DIV + SPEED_STEP)
      stepped = period - PW'(SPEED_STEP);
  end

  assign period_nxt = speed_up ? stepped : period;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period    <= PW'(TICK_DIV);
      active    <= PW'(TICK_DIV);
      count     <= '0;
      move_tick <= 1'b0;
    end else begin
      move_tick <= 1'b0;
      if (clear) begin
        period <= PW'(TICK_DIV);
        active <= PW'(TICK_DIV);
        count  <= '0;
      end else begin
        period <= period_nxt;
        if (run) begin
          if (count == active - PW'(1)) begin
            count     <= '0;
            active    <= period_nxt;
            move_tick <= 1'b1;
          end else begin
            count <= count + PW'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: game FSM, direction latch, collision eval, blink.
// In: clk rst start_p pause_p dir_p hits. Out: state tick dir coll apples disp.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int MIN_DIV    = DEF_MIN_DIV,
  parameter int SPEED_STEP = DEF_SPEED_STEP,
  parameter int MAX_SCORE  = DEF_MAX_SCORE,
  parameter int BLINK_DIV  = DEF_BLINK_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_p,
  input  logic       pause_p,
  input  logic [3:0] dir_p,
  input  logic       apple_hit,
  input  logic       wall_hit,
  input  logic       self_hit,
  output logic [2:0] state,
  output logic       move_tick,
  output logic [1:0] cur_dir,
  output logic       good_coll,
  output logic       bad_coll,
  output logic [7:0] apples,
  output logic       display_en
);

  localparam int BW = $clog2(BLINK_DIV + 1);

  state_t        state_q;
  state_t        state_d;
  dir_t          cur_q;
  dir_t          pend_q;
  dir_t          dir_req;
  logic          eval_q;
  logic [7:0]    apples_q;
  logic [3:0]    sub_q;
  logic          good_q;
  logic          bad_q;
  logic          disp_q;
  logic [BW-1:0] blink_q;

  logic clear;
  logic hit_bad;
  logic hit_apple;
  logic win;
  logic eat;
  logic good_d;
  logic bad_d;
  logic speed_up;
  logic timer_run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A collision in the eval cycle outranks a pause request.
  always_comb begin
    state_d   = state_q;
    good_d    = 1'b0;
    bad_d     = 1'b0;
    eat       = 1'b0;
    hit_bad   = eval_q & (wall_hit | self_hit);
    hit_apple = eval_q & apple_hit & ~hit_bad;
    win       = hit_apple &&
                (apples_q == 8'(MAX_SCORE - 1));
    unique case (state_q)
      IDLE: begin
        if (start_p) state_d = RUN;
      end
      RUN, PAUSE: begin
        if (hit_bad) begin
          bad_d   = 1'b1;
          state_d = OVER;
        end else begin
          if (hit_apple) begin
            good_d = 1'b1;
            eat    = 1'b1;
          end
          if (win) begin
            bad_d   = 1'b1;
            state_d = WIN;
          end else if (pause_p) begin
            state_d = (state_q == RUN) ? PAUSE : RUN;
          end
        end
      end
      OVER, WIN: begin
        if (start_p) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    clear = (state_d == IDLE);
  end

  assign speed_up  = eat && (sub_q == 4'd9);
  assign timer_run = (state_q == RUN) && !bad_d;
  assign dir_req   = pick_dir(dir_p);

  move_timer #(
    .TICK_DIV   (TICK_DIV),
    .MIN_DIV    (MIN_DIV),
    .SPEED_STEP (SPEED_STEP)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .run       (timer_run),
    .speed_up  (speed_up),
    .move_tick (move_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q    <= RIGHT;
      pend_q   <= RIGHT;
      eval_q   <= 1'b0;
      apples_q <= '0;
      sub_q    <= '0;
      good_q   <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      good_q <= good_d;
      bad_q  <= bad_d;
      eval_q <= move_tick & ~clear;
      if (clear) begin
        cur_q    <= RIGHT;
        pend_q   <= RIGHT;
        apples_q <= '0;
        sub_q    <= '0;
      end else begin
        if (state_q == RUN && |dir_p &&
            dir_req != opposite(cur_q))
          pend_q <= dir_req;
        if (move_tick)
          cur_q <= pend_q;
        if (eat) begin
          apples_q <= apples_q + 8'd1;
          sub_q    <= speed_up ? 4'd0 : sub_q + 4'd1;
        end
      end
    end
  end

  // Blink runs only while staying in OVER; any other path
  // (including OVER entry and exit) restarts it lit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_q  <= 1'b1;
      blink_q <= '0;
    end else if (state_q == OVER && state_d == OVER) begin
      if (blink_q == BW'(BLINK_DIV - 1)) begin
        blink_q <= '0;
        disp_q  <= ~disp_q;
      end else begin
        blink_q <= blink_q + BW'(1);
      end
    end else begin
      disp_q  <= 1'b1;
      blink_q <= '0;
    end
  end

  assign state      = state_q;
  assign cur_dir    = cur_q;
  assign good_coll  = good_q;
  assign bad_coll   = bad_q;
  assign apples     = apples_q;
  assign display_en = disp_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb_snake_game_ctrl: directed self-checking bench for snake_game_ctrl.
// Small timing parameters keep every scenario within a few hundred cycles.
module tb_snake_game_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_p;
  logic       pause_p;
  logic [3:0] dir_p;
  logic       apple_hit;
  logic       wall_hit;
  logic       self_hit;
  logic [2:0] state;
  logic       move_tick;
  logic [1:0] cur_dir;
  logic       good_coll;
  logic       bad_coll;
  logic [7:0] apples;
  logic       display_en;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int tlast  = 0;

  snake_game_ctrl #(
    .TICK_DIV   (4),
    .MIN_DIV    (2),
    .SPEED_STEP (1),
    .MAX_SCORE  (32),
    .BLINK_DIV  (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_p    (start_p),
    .pause_p    (pause_p),
    .dir_p      (dir_p),
    .apple_hit  (apple_hit),
    .wall_hit   (wall_hit),
    .self_hit   (self_hit),
    .state      (state),
    .move_tick  (move_tick),
    .cur_dir    (cur_dir),
    .good_coll  (good_coll),
    .bad_coll   (bad_coll),
    .apples     (apples),
    .display_en (display_en)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic wait_mt(output int spacing);
    int k;
    k = 0;
    while (move_tick !== 1'b1 && k < 64) begin
      tick();
      k++;
    end
    chk("tick_seen", {31'd0, move_tick}, 32'd1);
    spacing = cyc - tlast;
    tlast   = cyc;
  endtask

  initial begin
    int  sp;
    int  mark;
    int  exp_sp;
    logic saw;

    rst = 1'b1;
    start_p = 1'b0;
    pause_p = 1'b0;
    dir_p = 4'd0;
    apple_hit = 1'b0;
    wall_hit = 1'b0;
    self_hit = 1'b0;
    tick();
    tick();
    chk("rst_state", state, 0);
    chk("rst_tick", move_tick, 0);
    chk("rst_dir", cur_dir, 3);
    chk("rst_good", good_coll, 0);
    chk("rst_bad", bad_coll, 0);
    chk("rst_apples", apples, 0);
    chk("rst_disp", display_en, 1);
    rst = 1'b0;
    tick();

    pause_p = 1'b1;
    tick();
    pause_p = 1'b0;
    chk("idle_pause_ign", state, 0);

    // Game 1: ticks, direction, pause, apples up to WIN
    start_p = 1'b1;
    tick();
    start_p = 1'b0;
    chk("run_entry", state, 1);
    mark = cyc;
    wait_mt(sp);
    chk("first_tick", cyc - mark, 4);
    chk("first_dir", cur_dir, 3);
    chk("first_good", good_coll, 0);
    chk("first_bad", bad_coll, 0);
    tick();
    wait_mt(sp);
    chk("tick_period", sp, 4);

    dir_p = 4'b0010;
    tick();
    dir_p = 4'd0;
    chk("reverse_drop", cur_dir, 3);
    dir_p = 4'b1010;
    tick();
    dir_p = 4'd0;
    wait_mt(sp);
    chk("dir_hold", cur_dir, 3);
    tick();
    chk("dir_prio_up", cur_dir, 0);

    // count is 2 in the cycle that carries pause_p
    tick();
    pause_p = 1'b1;
    tick();
    pause_p = 1'b0;
    chk("paused", state, 2);
    dir_p = 4'b0010;
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      dir_p = 4'd0;
      if (move_tick) saw = 1'b1;
    end
    chk("pause_no_tick", saw, 0);
    pause_p = 1'b1;
    tick();
    pause_p = 1'b0;
    chk("resumed", state, 1);
    mark = cyc - 1;
    wait_mt(sp);
    chk("resume_gap", cyc - mark, 2);
    tick();
    chk("pause_dir_ign", cur_dir, 0);

    for (int i = 1; i <= 32; i++) begin
      wait_mt(sp);
      exp_sp = (i <= 11) ? 4 : (i <= 21) ? 3 : 2;
      chk($sformatf("gap_%0d", i), sp, exp_sp);
      tick();
      apple_hit = 1'b1;
      tick();
      apple_hit = 1'b0;
      chk($sformatf("good_%0d", i), good_coll, 1);
      chk($sformatf("apples_%0d", i), apples, i);
      chk($sformatf("bad_%0d", i), bad_coll,
          (i == 32) ? 1 : 0);
    end
    chk("win_state", state, 4);
    tick();
    chk("win_bad_once", bad_coll, 0);
    chk("win_good_once", good_coll, 0);
    chk("win_no_tick", move_tick, 0);
    chk("win_disp", display_en, 1);
    start_p = 1'b1;
    tick();
    start_p = 1'b0;
    chk("win_to_idle", state, 0);
    chk("idle_apples", apples, 0);
    chk("idle_dir", cur_dir, 3);

    // Game 2: apple + wall together, then blink
    start_p = 1'b1;
    tick();
    start_p = 1'b0;
    mark = cyc;
    wait_mt(sp);
    chk("reload_period", cyc - mark, 4);
    tick();
    apple_hit = 1'b1;
    wall_hit = 1'b1;
    tick();
    apple_hit = 1'b0;
    wall_hit = 1'b0;
    chk("both_bad", bad_coll, 1);
    chk("both_good", good_coll, 0);
    chk("both_over", state, 3);
    chk("both_apples", apples, 0);
    for (int j = 1; j <= 15; j++) begin
      tick();
      chk($sformatf("blink_%0d", j), display_en,
          ((j / 5) % 2 == 0) ? 1 : 0);
    end
    chk("over_bad_once", bad_coll, 0);
    start_p = 1'b1;
    tick();
    start_p = 1'b0;
    chk("over_to_idle", state, 0);
    chk("over_disp", display_en, 1);

    // Game 3: async reset mid-run
    start_p = 1'b1;
    tick();
    start_p = 1'b0;
    dir_p = 4'b1000;
    tick();
    dir_p = 4'd0;
    wait_mt(sp);
    tick();
    chk("g3_dir", cur_dir, 0);
    apple_hit = 1'b1;
    tick();
    apple_hit = 1'b0;
    chk("g3_good", good_coll, 1);
    rst = 1'b1;
    #1;
    chk("arst_state", state, 0);
    chk("arst_tick", move_tick, 0);
    chk("arst_dir", cur_dir, 3);
    chk("arst_good", good_coll, 0);
    chk("arst_bad", bad_coll, 0);
    chk("arst_apples", apples, 0);
    chk("arst_disp", display_en, 1);
    tick();
    rst = 1'b0;
    tick();
    chk("arst_idle", state, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
